seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
- Serial pattern generator, the transmit side for the team's serial sequence detector.
- Latches a programmed bit pattern and shifts it out one bit per accepted handshake, MSB of the active length first.
- Repeats the pattern a programmed number of times, with an optional idle gap between repetitions.
- Used on-chip for self-test of the detector path and as stimulus source on the shared I/O pins.

Parameters:
- PAT_W, 8: maximum pattern length in bits.
- REP_W, 4: width of repeat-count field.
- GAP_W, 4: width of inter-repetition gap field (cycles).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin transmission; sampled only in IDLE
- abort  input  1  terminate transmission immediately
- pattern  input  PAT_W  bit pattern; latched on accepted start
- pat_len  input  $clog2(PAT_W)+1  active length; latched on start
- rep_cnt  input  REP_W  extra repetitions; total sends = rep_cnt+1; latched on start
- gap_len  input  GAP_W  idle cycles between repetitions; latched on start
- bit_ready  input  1  sink ready to accept bit_out
- bit_out  output  1  current serial bit
- bit_valid  output  1  bit_out is valid
- frame_start  output  1  high with the first bit of every repetition
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the final bit of the final repetition is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE; bit_out=0, bit_valid=0, frame_start=0, busy=0, done=0; internal shift register, bit counter, repeat counter and gap counter all cleared.
- States: IDLE, SEND, GAP, FIN.
- IDLE: on start=1 and abort=0, latch all configuration; go to SEND next cycle.
  - busy rises, and bit_valid rises with the first bit, one cycle after start (latency 1).
- pat_len: 0 or any value greater than PAT_W is treated as PAT_W.
  - Bits are sent from pattern[len-1] down to pattern[0].
- SEND: bit_valid=1, bit_out = current bit.
  - A transfer occurs when bit_valid && bit_ready.
  - Without a transfer, bit_out and frame_start hold stable, with no limit on stall length.
  - On each transfer, advance to the next bit in the same state.
  - On transfer of bit 0:
    - if repetitions remain and gap_len>0, go to GAP;
    - if repetitions remain and gap_len=0, restart at bit len-1 with no idle cycle, so back-to-back bits stay continuous;
    - if none remain, go to FIN.
- frame_start: 1 while the first bit (index len-1) of any repetition is presented, including while stalled; 0 otherwise.
- GAP: bit_valid=0, bit_out=0 for exactly gap_len cycles, then SEND with first bit and the repeat counter decremented.
- FIN: done=1 for one cycle, bit_valid=0; return to IDLE next cycle.
- abort=1 in SEND, GAP or FIN: next state IDLE, bit_valid=0, done not pulsed, counters cleared.
  - An abort coincident with a transfer still ends the operation; the sink may have consumed that bit.
- start while busy: ignored; configuration inputs are not re-sampled until IDLE.
- start and abort together in IDLE: abort wins, stay IDLE.
- Reset mid-operation: immediate return to reset values regardless of state or handshake.
- Counters never wrap: the bit counter is reloaded from the latched length, and the repeat counter stops at 0.

Test Plan:
- Single send: pattern=8'b1011_0010, pat_len=8, rep_cnt=0, gap_len=0, bit_ready=1 → bit_out 1,0,1,1,0,0,1,0 on 8 consecutive cycles starting one cycle after start; frame_start only on first; done pulses once the cycle after the last bit; busy low afterwards.
- Short length plus stall: pattern=8'hFD, pat_len=3, bit_ready low for 4 cycles during the second bit → bits 1,0,1; second bit held stable through the stall; exactly 3 transfers.
- Repeat with gap: pattern=8'h05, pat_len=3, rep_cnt=2, gap_len=2 → 101, 2 idle cycles, 101, 2 idle cycles, 101; frame_start 3 times; one done pulse; 13 cycles total from first bit to last bit.
- Back-to-back repeats: pat_len=4, pattern=4'b1001, rep_cnt=1, gap_len=0 → 10011001 with bit_valid continuously high for 8 cycles.
- Abort and ignored start: abort during the 3rd bit → bit_valid=0 next cycle, no done, busy low; a start asserted while busy is ignored; start with abort=1 in IDLE produces no activity.
- Async reset mid-SEND: rst pulsed between clock edges → all outputs 0 immediately; after release the next start behaves exactly as the first scenario.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first over a
// valid/ready bit stream, repeating it with an optional idle gap between sends.
module seq_pattern_tx #(
    parameter int PAT_W = 8,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PAT_W-1:0]       pattern,
    input  logic [$clog2(PAT_W):0] pat_len,
    input  logic [REP_W-1:0]       rep_cnt,
    input  logic [GAP_W-1:0]       gap_len,
    input  logic                   bit_ready,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic                   frame_start,
    output logic                   busy,
    output logic                   done
);

    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    // Handshake: a bit is transferred on a rising clk edge where bit_valid and
    // bit_ready are both high; bit_out/frame_start hold while bit_ready is low.
    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_q, shreg;
    logic [LEN_W-1:0] len_q, bit_cnt, eff_len;
    logic [REP_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_q, gap_cnt;
    logic             xfer, last_bit;

    always_comb begin
        eff_len = pat_len;
        if (pat_len == '0 || pat_len > PAT_W_L)
            eff_len = PAT_W_L;
    end

    assign xfer     = (state == SEND) && bit_ready;
    assign last_bit = (bit_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !abort) state_nxt = SEND;
            SEND: begin
                if (abort)
                    state_nxt = IDLE;
                else if (xfer && last_bit) begin
                    if (rep_q == '0)       state_nxt = FIN;
                    else if (gap_q != '0)  state_nxt = GAP;
                    else                   state_nxt = SEND;
                end
            end
            GAP: begin
                if (abort)
                    state_nxt = IDLE;
                else if (gap_cnt == GAP_W'(1))
                    state_nxt = SEND;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pattern is stored left-aligned so the active MSB always sits at shreg[PAT_W-1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= '0;
            shreg   <= '0;
            len_q   <= '0;
            bit_cnt <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
        end else if (state == IDLE) begin
            if (start && !abort) begin
                pat_q   <= pattern << (PAT_W_L - eff_len);
                shreg   <= pattern << (PAT_W_L - eff_len);
                len_q   <= eff_len;
                bit_cnt <= eff_len - 1'b1;
                rep_q   <= rep_cnt;
                gap_q   <= gap_len;
                gap_cnt <= '0;
            end
        end else if (abort) begin
            shreg   <= '0;
            bit_cnt <= '0;
            rep_q   <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                SEND: begin
                    if (xfer) begin
                        if (!last_bit) begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (rep_q != '0) begin
                            if (gap_q != '0) begin
                                gap_cnt <= gap_q;
                            end else begin
                                shreg   <= pat_q;
                                bit_cnt <= len_q - 1'b1;
                                rep_q   <= rep_q - 1'b1;
                            end
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GAP_W'(1)) begin
                        shreg   <= pat_q;
                        bit_cnt <= len_q - 1'b1;
                        rep_q   <= rep_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bit_out     = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            SEND: begin
                bit_valid   = 1'b1;
                bit_out     = shreg[PAT_W-1];
                frame_start = (bit_cnt == len_q - 1'b1);
            end
            // An abort arriving in FIN cancels the completion pulse.
            FIN:     done = !abort;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a queue-of-symbols model predicts every output each
// cycle, and directed scenarios pin the received bit streams to literal values.
module tb_seq_pattern_tx;

    logic       clk, rst, start, abort, bit_ready;
    logic [7:0] pattern;
    logic [3:0] pat_len, rep_cnt, gap_len;
    logic       bit_out, bit_valid, frame_start, busy, done;

    seq_pattern_tx #(.PAT_W(8), .REP_W(4), .GAP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .pat_len(pat_len), .rep_cnt(rep_cnt), .gap_len(gap_len),
        .bit_ready(bit_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .frame_start(frame_start), .busy(busy), .done(done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: queue of symbols {is_bit, first, value} ----------------
    logic [2:0] exp_q[$];
    logic       m_fin;

    task automatic build(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                         input logic [3:0] g);
        int len;
        len = (l == 0 || l > 8) ? 8 : int'(l);
        for (int rr = 0; rr <= int'(r); rr++) begin
            for (int i = len - 1; i >= 0; i--)
                exp_q.push_back({1'b1, (i == len - 1), p[i]});
            if (rr < int'(r))
                for (int k = 0; k < int'(g); k++)
                    exp_q.push_back(3'b000);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_fin = 1'b0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (exp_q.size() == 0) begin
            if (start && !abort) build(pattern, pat_len, rep_cnt, gap_len);
        end else if (abort) begin
            exp_q.delete();
        end else if (exp_q[0][2]) begin
            if (bit_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_fin = 1'b1;
            end
        end else begin
            void'(exp_q.pop_front());
        end
    end

    // ---------------- compare + transfer log ----------------
    logic [31:0] rx_bits;
    int rx_n, fs_n, done_n, done_cyc, first_cyc, last_cyc, run, max_run;

    task automatic clear_log();
        rx_bits = '0; rx_n = 0; fs_n = 0; done_n = 0; done_cyc = -1;
        first_cyc = -1; last_cyc = -1; run = 0; max_run = 0;
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        logic       hv;
        hv = (exp_q.size() != 0) && exp_q[0][2];
        e = {hv && exp_q[0][0], hv, hv && exp_q[0][1],
             (exp_q.size() != 0) || m_fin, m_fin && !abort};
        check("cycle_outputs", {bit_out, bit_valid, frame_start, busy, done}, e);
        if (bit_valid && bit_ready) begin
            rx_bits = {rx_bits[30:0], bit_out};
            rx_n++;
            if (frame_start) fs_n++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        if (done) begin done_n++; done_cyc = cyc; end
        run = bit_valid ? run + 1 : 0;
        if (run > max_run) max_run = run;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                        input logic [3:0] g);
        @(posedge clk); #1;
        start = 1'b1; pattern = p; pat_len = l; rep_cnt = r; gap_len = g;
        @(posedge clk); #1;
        // scrambled configuration must not be picked up while busy
        start = 1'b0; pattern = ~p; pat_len = 4'd1; rep_cnt = 4'hF; gap_len = 4'hF;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || m_fin) && n < limit);
        if (exp_q.size() != 0 || m_fin) check("wait_idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic scenario_single(input string tag);
        clear_log();
        send(8'b1011_0010, 4'd8, 4'd0, 4'd0);
        wait_idle(60);
        check({tag, "_bits"}, rx_bits[7:0], 8'hB2);
        check({tag, "_nbits"}, rx_n, 8);
        check({tag, "_frame_start"}, fs_n, 1);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_done_timing"}, done_cyc, last_cyc + 1);
        check({tag, "_valid_run"}, max_run, 8);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; bit_ready = 1'b1;
        pattern = '0; pat_len = '0; rep_cnt = '0; gap_len = '0;
        clear_log();
        #12;
        check("reset_outputs", {bit_out, bit_valid, frame_start, busy, done}, 5'b0);
        rst = 1'b0;

        scenario_single("single");

        // short length with a 4-cycle stall on the second bit
        clear_log();
        send(8'hFD, 4'd3, 4'd0, 4'd0);
        @(posedge clk); #1 bit_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_hold", {bit_valid, bit_out, frame_start}, 3'b100);
        end
        @(posedge clk); #1 bit_ready = 1'b1;
        wait_idle(60);
        check("stall_bits", rx_bits[2:0], 3'b101);
        check("stall_nbits", rx_n, 3);
        check("stall_done", done_n, 1);

        // repeat with gap
        clear_log();
        send(8'h05, 4'd3, 4'd2, 4'd2);
        wait_idle(80);
        check("gap_bits", rx_bits[8:0], 9'b101_101_101);
        check("gap_nbits", rx_n, 9);
        check("gap_frame_start", fs_n, 3);
        check("gap_done", done_n, 1);
        check("gap_span", last_cyc - first_cyc + 1, 13);

        // back-to-back repeats, no gap
        clear_log();
        send(8'h09, 4'd4, 4'd1, 4'd0);
        wait_idle(60);
        check("b2b_bits", rx_bits[7:0], 8'b1001_1001);
        check("b2b_valid_run", max_run, 8);
        check("b2b_frame_start", fs_n, 2);

        // length boundaries: 0 and >PAT_W mean full width
        clear_log();
        send(8'h96, 4'd0, 4'd0, 4'd0);
        wait_idle(60);
        check("len0_bits", rx_bits[7:0], 8'h96);
        check("len0_nbits", rx_n, 8);
        clear_log();
        send(8'h3C, 4'd12, 4'd0, 4'd0);
        wait_idle(60);
        check("len12_bits", rx_bits[7:0], 8'h3C);
        check("len12_nbits", rx_n, 8);

        // length 1, one-cycle gap, then max repeat count
        clear_log();
        send(8'h01, 4'd1, 4'd1, 4'd1);
        wait_idle(60);
        check("len1_gap1_bits", rx_bits[1:0], 2'b11);
        check("len1_gap1_span", last_cyc - first_cyc + 1, 3);
        clear_log();
        send(8'h01, 4'd1, 4'd15, 4'd0);
        wait_idle(80);
        check("maxrep_nbits", rx_n, 16);
        check("maxrep_frame_start", fs_n, 16);
        check("maxrep_done", done_n, 1);

        // abort on the third bit, with a start attempted while busy
        clear_log();
        send(8'hB2, 4'd8, 4'd0, 4'd0);
        @(posedge clk); #1;
        start = 1'b1; pattern = 8'hFF; pat_len = 4'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        check("abort_third_bit", {bit_valid, bit_out}, 2'b11);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_after", {bit_valid, busy, done}, 3'b000);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_n, 0);
        check("abort_nbits", rx_n, 3);
        check("abort_bits", rx_bits[2:0], 3'b101);
        check("abort_busy_stays_low", busy, 0);

        // start and abort together in IDLE
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("start_abort_idle", {busy, bit_valid}, 2'b00);
        end

        // asynchronous reset between edges in mid-send
        clear_log();
        send(8'hB2, 4'd8, 4'd0, 4'd0);
        @(posedge clk); #3 rst = 1'b1;
        #1 check("async_reset_outputs", {bit_out, bit_valid, frame_start, busy, done}, 5'b0);
        #4 rst = 1'b0;
        scenario_single("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
